// File: rtl/parking_gate_sequencer.sv
// Parking gate sequencer: debounced entry/exit lanes, independent gate FSMs and a
// report stage that serialises entry/exit events toward the parking controller.
module parking_gate_sequencer #(
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned GATE_TIMEOUT    = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        entry_sensor,
   input  logic        entry_uni_badge,
   input  logic        exit_sensor,
   input  logic        exit_uni_badge,
   input  logic        is_uni_vacated_space,
   input  logic        is_vacated_space,
   output logic        entry_gate_open,
   output logic        exit_gate_open,
   output logic        entry_denied,
   output logic        car_entered,
   output logic        is_uni_car_entered,
   output logic        car_exited,
   output logic        is_uni_car_exited,
   output logic [15:0] denied_count
);

   localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned ToW = $clog2(GATE_TIMEOUT + 1);

   typedef enum logic [2:0] {E_IDLE, E_DECIDE, E_OPEN, E_DENY, E_REPORT} entry_state_e;
   typedef enum logic [1:0] {X_IDLE, X_OPEN, X_REPORT} exit_state_e;
   typedef enum logic [1:0] {R_IDLE, R_QUAL, R_PULSE, R_GAP} report_state_e;

   // Lane index 0 is entry, 1 is exit.
   logic [1:0]     raw;
   logic [1:0]     lvl_q;
   logic [1:0]     rise_q;
   logic [1:0]     fall_q;
   logic [DbW-1:0] db_cnt_q [2];

   entry_state_e   e_q, e_d;
   exit_state_e    x_q, x_d;
   report_state_e  r_q, r_d;
   logic           e_badge_q, e_badge_d;
   logic           x_badge_q, x_badge_d;
   logic [ToW-1:0] open_cnt_q, open_cnt_d;
   logic           deny_inc;
   logic           r_ready, e_ack, x_ack;
   logic           r_is_exit_q, r_is_exit_d;
   logic           uqe_d, uqx_d;

   assign raw = {exit_sensor, entry_sensor};

   // Debouncers: level flips after DEBOUNCE_CYCLES consecutive mismatching samples,
   // emitting a one-cycle rise/fall pulse in the cycle after the flip edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         lvl_q  <= '0;
         rise_q <= '0;
         fall_q <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            rise_q[i] <= 1'b0;
            fall_q[i] <= 1'b0;
            if (raw[i] == lvl_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
               lvl_q[i]    <= raw[i];
               db_cnt_q[i] <= '0;
               rise_q[i]   <= raw[i];
               fall_q[i]   <= ~raw[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Report stage accepts a new event when idle or in the gap after a pulse; entry wins.
   assign r_ready = (r_q == R_IDLE) || (r_q == R_GAP);
   assign e_ack   = r_ready && (e_q == E_REPORT);
   assign x_ack   = r_ready && (x_q == X_REPORT) && !e_ack;

   // Entry FSM next state.
   always_comb begin
      e_d        = e_q;
      e_badge_d  = e_badge_q;
      open_cnt_d = open_cnt_q;
      deny_inc   = 1'b0;
      unique case (e_q)
         E_IDLE: begin
            if (rise_q[0]) begin
               e_d       = E_DECIDE;
               e_badge_d = entry_uni_badge;
            end
         end
         E_DECIDE: begin
            open_cnt_d = '0;
            if (e_badge_q ? is_uni_vacated_space : is_vacated_space) begin
               e_d = E_OPEN;
            end else begin
               e_d      = E_DENY;
               deny_inc = 1'b1;
            end
         end
         E_OPEN: begin
            if (fall_q[0]) begin
               e_d = E_REPORT;
            end else if (open_cnt_q == ToW'(GATE_TIMEOUT - 1)) begin
               e_d = E_IDLE;
            end else begin
               open_cnt_d = open_cnt_q + 1'b1;
            end
         end
         E_DENY:   if (fall_q[0]) e_d = E_IDLE;
         E_REPORT: if (e_ack) e_d = E_IDLE;
         default:  e_d = E_IDLE;
      endcase
   end

   // Exit FSM next state; no capacity check and no timeout.
   always_comb begin
      x_d       = x_q;
      x_badge_d = x_badge_q;
      unique case (x_q)
         X_IDLE: begin
            if (rise_q[1]) begin
               x_d       = X_OPEN;
               x_badge_d = exit_uni_badge;
            end
         end
         X_OPEN:   if (fall_q[1]) x_d = X_REPORT;
         X_REPORT: if (x_ack) x_d = X_IDLE;
         default:  x_d = X_IDLE;
      endcase
   end

   // Report stage next state: qualifier cycle, pulse cycle, gap cycle.
   always_comb begin
      r_d         = r_q;
      r_is_exit_d = r_is_exit_q;
      uqe_d       = is_uni_car_entered;
      uqx_d       = is_uni_car_exited;
      unique case (r_q)
         R_IDLE, R_GAP: begin
            r_d = R_IDLE;
            if (e_ack) begin
               r_d         = R_QUAL;
               r_is_exit_d = 1'b0;
               uqe_d       = e_badge_q;
            end else if (x_ack) begin
               r_d         = R_QUAL;
               r_is_exit_d = 1'b1;
               uqx_d       = x_badge_q;
            end
         end
         R_QUAL:  r_d = R_PULSE;
         R_PULSE: r_d = R_GAP;
         default: r_d = R_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         e_q                <= E_IDLE;
         x_q                <= X_IDLE;
         r_q                <= R_IDLE;
         e_badge_q          <= 1'b0;
         x_badge_q          <= 1'b0;
         open_cnt_q         <= '0;
         r_is_exit_q        <= 1'b0;
         entry_gate_open    <= 1'b0;
         exit_gate_open     <= 1'b0;
         entry_denied       <= 1'b0;
         car_entered        <= 1'b0;
         car_exited         <= 1'b0;
         is_uni_car_entered <= 1'b0;
         is_uni_car_exited  <= 1'b0;
         denied_count       <= '0;
      end else begin
         e_q                <= e_d;
         x_q                <= x_d;
         r_q                <= r_d;
         e_badge_q          <= e_badge_d;
         x_badge_q          <= x_badge_d;
         open_cnt_q         <= open_cnt_d;
         r_is_exit_q        <= r_is_exit_d;
         entry_gate_open    <= (e_d == E_OPEN);
         exit_gate_open     <= (x_d == X_OPEN);
         entry_denied       <= (e_d == E_DENY);
         car_entered        <= (r_d == R_PULSE) && !r_is_exit_d;
         car_exited         <= (r_d == R_PULSE) && r_is_exit_d;
         is_uni_car_entered <= uqe_d;
         is_uni_car_exited  <= uqx_d;
         if (deny_inc && (denied_count != 16'hFFFF)) denied_count <= denied_count + 16'd1;
      end
   end

endmodule
